// File: rtl/cb_cdc_tx.sv
// Source half of a toggle req/ack multi-bit CDC: holds a word on xfer_dat,
// flips xfer_req once per word and waits for the synchronised ack parity to match.
module cb_cdc_tx #(
    parameter int              U_DLY      = 1,
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] INT_VALUE = '0,
    parameter int              ACK_STAGES = 2,
    parameter int              TO_W       = 16,
    parameter logic [TO_W-1:0] TO_CYCLES  = '1
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             src_rdy,
    output logic [WIDTH-1:0] xfer_dat,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    if (ACK_STAGES < 2 || U_DLY < 0) begin : g_bad_param
        $error("cb_cdc_tx: ACK_STAGES must be >= 2 and U_DLY >= 0");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_ACK
    } state_e;

    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST = TO_CYCLES - TO_ONE;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        dat_q, dat_d;
    logic                    req_q, req_d;
    logic [TO_W-1:0]         cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    to_q, to_d;
    logic [ACK_STAGES-1:0]   ack_sync_q;
    logic                    ack_s;

    assign ack_s = ack_sync_q[ACK_STAGES-1];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dat_q      <= INT_VALUE;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            to_q       <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            dat_q      <= dat_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            to_q       <= to_d;
            ack_sync_q <= {ack_sync_q[ACK_STAGES-2:0], xfer_ack};
        end
    end

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (src_vld) begin
                    dat_d   = src_dat;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                req_d   = ~req_q;
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (cnt_q != '1) cnt_d = cnt_q + TO_ONE;
                // Ack match has priority; the counter saturates past TO_LAST so the timeout fires once.
                if (ack_s == req_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (TO_CYCLES != '0 && cnt_q == TO_LAST) begin
                    to_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign src_rdy     = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign xfer_dat    = dat_q;
    assign xfer_req    = req_q;
    assign done        = done_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_cb_cdc_tx.sv
// Directed bench for cb_cdc_tx with a 3-cycle req->ack loopback and a forced-ack mode.
module tb_cb_cdc_tx;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        src_vld = 1'b0;
    logic [15:0] src_dat = '0;
    logic        src_rdy;
    logic [15:0] xfer_dat;
    logic        xfer_req;
    logic        xfer_ack;
    logic        busy, done, timeout_err;

    logic [2:0]  lb_q;
    logic        ack_mode  = 1'b0;
    logic        ack_force = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk_sys = ~clk_sys;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) lb_q <= '0;
        else        lb_q <= {lb_q[1:0], xfer_req};
    end
    assign xfer_ack = ack_mode ? ack_force : lb_q[2];

    cb_cdc_tx #(
        .WIDTH     (16),
        .INT_VALUE (16'h0000),
        .ACK_STAGES(2),
        .TO_W      (16),
        .TO_CYCLES (16'd8)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .src_vld    (src_vld),
        .src_dat    (src_dat),
        .src_rdy    (src_rdy),
        .xfer_dat   (xfer_dat),
        .xfer_req   (xfer_req),
        .xfer_ack   (xfer_ack),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        src_vld = 1'b0;
        ack_mode = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits up to 'limit' ticks for done; returns the tick index it appeared on (0 = never).
    task automatic wait_done(input int limit, output int at);
        at = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (done && at == 0) at = i;
            if (at != 0) break;
        end
    endtask

    initial begin
        int at, pulses;
        logic [15:0] held;

        // 1: reset state
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_src_rdy", 32'(src_rdy), 32'd1);
        check("rst_req",     32'(xfer_req), 32'd0);
        check("rst_dat",     32'(xfer_dat), 32'h0000);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_to",      32'(timeout_err), 32'd0);
        do_reset();

        // 2: single word
        src_vld = 1'b1; src_dat = 16'hA55A;
        tick();
        src_vld = 1'b0;
        check("s_dat",  32'(xfer_dat), 32'hA55A);
        check("s_req0", 32'(xfer_req), 32'd0);
        check("s_busy", 32'(busy), 32'd1);
        check("s_rdy0", 32'(src_rdy), 32'd0);
        tick();
        check("s_req1", 32'(xfer_req), 32'd1);
        wait_done(20, at);
        check("s_done_at", 32'(at), 32'd6);
        check("s_rdy_w_done", 32'(src_rdy), 32'd1);
        tick();
        check("s_done_once", 32'(done), 32'd0);
        check("s_idle", 32'(busy), 32'd0);

        // 3: back-to-back
        do_reset();
        src_vld = 1'b1; src_dat = 16'h0001;
        tick();
        src_dat = 16'h0002;
        check("b_dat1", 32'(xfer_dat), 32'h0001);
        at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (busy) check("b_dat1_hold", 32'(xfer_dat), 32'h0001);
            if (done) begin at = i; break; end
        end
        check("b_done1_at", 32'(at), 32'd7);
        check("b_req1", 32'(xfer_req), 32'd1);
        check("b_rdy_w_done", 32'(src_rdy), 32'd1);
        check("b_dat_still1", 32'(xfer_dat), 32'h0001);
        tick();
        src_vld = 1'b0;
        check("b_dat2", 32'(xfer_dat), 32'h0002);
        check("b_busy2", 32'(busy), 32'd1);
        tick();
        check("b_req2", 32'(xfer_req), 32'd0);
        wait_done(20, at);
        check("b_done2_at", 32'(at), 32'd6);
        check("b_dat2_end", 32'(xfer_dat), 32'h0002);

        // 6: inputs ignored while busy
        do_reset();
        src_vld = 1'b1; src_dat = 16'h5A5A;
        tick();
        src_vld = 1'b0;
        tick();
        held = xfer_dat;
        check("i_dat_cap", 32'(held), 32'h5A5A);
        at = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) begin
                src_vld = 1'($urandom_range(0, 1));
                src_dat = 16'($urandom);
            end else begin
                src_vld = 1'b0;
            end
            tick();
            if (busy) begin
                check("i_dat_hold", 32'(xfer_dat), 32'h5A5A);
                check("i_req_hold", 32'(xfer_req), 32'd1);
            end
            if (done) begin at = i; src_vld = 1'b0; break; end
        end
        check("i_done_seen", 32'(at != 0), 32'd1);
        check("i_done_dat", 32'(xfer_dat), 32'h5A5A);

        // 4: timeout then late ack
        do_reset();
        ack_mode = 1'b1; ack_force = 1'b0;
        src_vld = 1'b1; src_dat = 16'h00C3;
        tick();
        src_vld = 1'b0;
        tick();
        at = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (timeout_err) begin pulses++; if (at == 0) at = i; end
        end
        check("t_pulses", 32'(pulses), 32'd1);
        check("t_at", 32'(at), 32'd8);
        check("t_still_busy", 32'(busy), 32'd1);
        ack_force = 1'b1;
        wait_done(10, at);
        check("t_late_done_at", 32'(at), 32'd3);
        check("t_late_to", 32'(timeout_err), 32'd0);
        tick();
        check("t_idle", 32'(busy), 32'd0);
        check("t_rdy", 32'(src_rdy), 32'd1);

        // 5: mid-transfer reset
        do_reset();
        src_vld = 1'b1; src_dat = 16'hBEEF;
        tick();
        src_vld = 1'b0;
        repeat (3) tick();
        check("r_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("r_rdy",  32'(src_rdy), 32'd1);
        check("r_req",  32'(xfer_req), 32'd0);
        check("r_dat",  32'(xfer_dat), 32'h0000);
        check("r_busy", 32'(busy), 32'd0);
        check("r_done", 32'(done), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        src_vld = 1'b1; src_dat = 16'h1234;
        tick();
        src_vld = 1'b0;
        check("r_new_dat", 32'(xfer_dat), 32'h1234);
        tick();
        check("r_new_req", 32'(xfer_req), 32'd1);
        wait_done(20, at);
        check("r_new_done_at", 32'(at), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
